// File: rtl/tr_switch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tr_switch_pkg
// Shared types and constants for the multi-antenna T/R switch sequencer.
//   state_e      : sequencer states (guard, enable-settle, and settled states
//                  for the RX and TX directions)
//   DEF_*        : default parameter values
//   timer_width  : width of the shared guard/settle down-counter
//   sel_width    : width of the channel-select bus (minimum 1)
// -----------------------------------------------------------------------------
package tr_switch_pkg;

  typedef enum logic [2:0] {
    ST_GUARD_RX = 3'd0,
    ST_RX_ON    = 3'd1,
    ST_RX       = 3'd2,
    ST_GUARD_TX = 3'd3,
    ST_TX_ON    = 3'd4,
    ST_TX       = 3'd5
  } state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GUARD_CYC  = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_TX_MAX_CYC = 1024;

  // The counter must hold the longer of the two intervals.
  function automatic int timer_width(input int guard_cyc, input int settle_cyc);
    int longest;
    longest = (guard_cyc > settle_cyc) ? guard_cyc : settle_cyc;
    return $clog2(longest + 1);
  endfunction

  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Guard states are the all-enables-off states.
  function automatic logic is_guard(input state_e s);
    return (s == ST_GUARD_RX) || (s == ST_GUARD_TX);
  endfunction

endpackage

// File: rtl/tr_switch_sequencer_if.sv
// -----------------------------------------------------------------------------
// tr_switch_sequencer_if
// Bundles the modem-side handshake/data signals and the analog switch enables
// of the T/R switch sequencer.
//   master : modem / test side (drives tx_request, channel_sel, transmit, rx_in)
//   slave  : sequencer side (drives grants, qualified data, enables, status)
// Signals:
//   tx_request      level request/continue of a TX burst
//   channel_sel     antenna select, sampled only in the settled RX state
//   transmit        TX sample from the modem
//   rx_in           sample from the LNA path
//   tx_grant        TX path settled, transmit forwarded
//   tx_out          transmit when tx_grant, else 0
//   rx_valid        RX path settled
//   receive         rx_in when rx_valid, else 0
//   enable_transmit one-hot-or-zero TX switch enables
//   enable_receive  one-hot-or-zero RX switch enables
//   busy            high in any state other than settled RX
//   sel_error       sticky out-of-range channel select flag
// -----------------------------------------------------------------------------
interface tr_switch_sequencer_if
  import tr_switch_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int SEL_W = sel_width(NUM_CH);

  logic              tx_request;
  logic [SEL_W-1:0]  channel_sel;
  logic [DATA_W-1:0] transmit;
  logic [DATA_W-1:0] rx_in;
  logic              tx_grant;
  logic [DATA_W-1:0] tx_out;
  logic              rx_valid;
  logic [DATA_W-1:0] receive;
  logic [NUM_CH-1:0] enable_transmit;
  logic [NUM_CH-1:0] enable_receive;
  logic              busy;
  logic              sel_error;

  modport master (
    output tx_request, channel_sel, transmit, rx_in,
    input  tx_grant, tx_out, rx_valid, receive,
    input  enable_transmit, enable_receive, busy, sel_error
  );

  modport slave (
    input  tx_request, channel_sel, transmit, rx_in,
    output tx_grant, tx_out, rx_valid, receive,
    output enable_transmit, enable_receive, busy, sel_error
  );

endinterface

// File: rtl/tr_switch_sequencer_guard_timer.sv
// -----------------------------------------------------------------------------
// tr_guard_timer
// Loadable down-counter shared by all timed sequencer states. The owner loads
// the interval on state entry; o_done flags the last cycle of the interval
// (count == 1). The counter parks at 0 while no interval is running.
// Ports:
//   i_clk       clock (rising edge)
//   i_rst       synchronous active-high reset, loads RST_VAL
//   i_load      load strobe
//   i_load_val  interval to load
//   o_done      high while the count is 1
// -----------------------------------------------------------------------------
module tr_guard_timer #(
  parameter int                CNT_W   = 4,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tr_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tr_switch_sequencer
// Break-before-make sequencer for a NUM_CH-antenna T/R front end. Drives
// one-hot-or-zero TX/RX switch enables with GUARD_CYC all-off cycles between
// directions and SETTLE_CYC cycles after an enable rises before data is
// qualified. All outputs are registered from the current state, so each
// output follows its state by one clock.
// Ports:
//   i_clk         clock (rising edge)
//   i_rst         synchronous active-high reset
//   io_sw         tr_switch_sequencer_if.slave: request, select, data,
//                 grants, enables and status (see interface file)
//   o_tx_timeout  sticky TX burst timeout (only with TR_SWITCH_TX_TIMEOUT_EN)
// Configuration:
//   TR_SWITCH_TX_TIMEOUT_EN  when defined, a TX burst is cut off after
//                            TX_MAX_CYC granted cycles and a new burst needs
//                            tx_request low for at least one cycle.
// -----------------------------------------------------------------------------
module tr_switch_sequencer
  import tr_switch_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GUARD_CYC  = DEF_GUARD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int TX_MAX_CYC = DEF_TX_MAX_CYC
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef TR_SWITCH_TX_TIMEOUT_EN
  output logic o_tx_timeout,
`endif
  tr_switch_sequencer_if.slave io_sw
);

  localparam int SEL_W = sel_width(NUM_CH);
  localparam int CNT_W = timer_width(GUARD_CYC, SETTLE_CYC);

  if (NUM_CH < 1 || GUARD_CYC < 1 || SETTLE_CYC < 1 || TX_MAX_CYC < 1) begin : g_param_check
    $error("tr_switch_sequencer: NUM_CH, GUARD_CYC, SETTLE_CYC and TX_MAX_CYC must be >= 1");
  end

  state_e             r_state;
  state_e             w_state_next;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_next;

  logic               w_sel_in_range;
  logic               w_sel_change;
  logic               w_tx_start;
  logic               w_tx_expired;
  logic               w_tx_blocked;

  logic               w_timer_load;
  logic [CNT_W-1:0]   w_timer_val;
  logic               w_timer_done;

  logic [NUM_CH-1:0]  w_sel_onehot;

  logic               r_tx_grant;
  logic [DATA_W-1:0]  r_tx_out;
  logic               r_rx_valid;
  logic [DATA_W-1:0]  r_receive;
  logic [NUM_CH-1:0]  r_en_tx;
  logic [NUM_CH-1:0]  r_en_rx;
  logic               r_busy;
  logic               r_sel_error;

  assign w_sel_in_range = int'(io_sw.channel_sel) < NUM_CH;
  assign w_sel_change   = w_sel_in_range && (io_sw.channel_sel != r_sel);
  assign w_tx_start     = io_sw.tx_request && !w_tx_blocked;
  assign w_sel_onehot   = NUM_CH'(1) << r_sel;

  // ---------------------------------------------------------------------------
  // Shared interval timer. Reset leaves it loaded with the guard interval so
  // the post-reset GUARD_RX state is timed like any other entry.
  // ---------------------------------------------------------------------------
  tr_guard_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(GUARD_CYC))
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_done     (w_timer_done)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_timer_load = 1'b0;
    w_timer_val  = CNT_W'(GUARD_CYC);

    case (r_state)
      ST_GUARD_RX: begin
        if (w_timer_done) w_state_next = ST_RX_ON;
      end

      ST_RX_ON: begin
        if (w_timer_done) w_state_next = ST_RX;
      end

      ST_RX: begin
        // TX wins over a simultaneous channel change and takes the new
        // channel; an out-of-range select keeps the old channel.
        if (w_tx_start) begin
          w_state_next = ST_GUARD_TX;
          if (w_sel_in_range) w_sel_next = io_sw.channel_sel;
        end else if (w_sel_change) begin
          w_state_next = ST_GUARD_RX;
          w_sel_next   = io_sw.channel_sel;
        end
      end

      ST_GUARD_TX: begin
        // A request dropped during the guard still completes the guard; the
        // RX side then comes back on the already-latched channel.
        if (w_timer_done) begin
          w_state_next = io_sw.tx_request ? ST_TX_ON : ST_RX_ON;
        end
      end

      ST_TX_ON: begin
        if (!io_sw.tx_request) begin
          w_state_next = ST_GUARD_RX;
        end else if (w_timer_done) begin
          w_state_next = ST_TX;
        end
      end

      ST_TX: begin
        if (!io_sw.tx_request || w_tx_expired) w_state_next = ST_GUARD_RX;
      end

      default: begin
        w_state_next = ST_GUARD_RX;
      end
    endcase

    if (w_state_next != r_state) begin
      w_timer_load = 1'b1;
      w_timer_val  = is_guard(w_state_next) ? CNT_W'(GUARD_CYC) : CNT_W'(SETTLE_CYC);
    end
  end

  // ---------------------------------------------------------------------------
  // State, channel and registered outputs. Reset clears the enables at the
  // same edge, so a burst cut by reset still sees the full guard before RX.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_GUARD_RX;
      r_sel       <= '0;
      r_tx_grant  <= 1'b0;
      r_tx_out    <= '0;
      r_rx_valid  <= 1'b0;
      r_receive   <= '0;
      r_en_tx     <= '0;
      r_en_rx     <= '0;
      r_busy      <= 1'b0;
      r_sel_error <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_en_rx     <= (r_state == ST_RX_ON || r_state == ST_RX) ? w_sel_onehot : '0;
      r_en_tx     <= (r_state == ST_TX_ON || r_state == ST_TX) ? w_sel_onehot : '0;
      r_rx_valid  <= (r_state == ST_RX);
      r_receive   <= (r_state == ST_RX) ? io_sw.rx_in : '0;
      r_tx_grant  <= (r_state == ST_TX) && io_sw.tx_request && !w_tx_expired;
      r_tx_out    <= ((r_state == ST_TX) && io_sw.tx_request && !w_tx_expired)
                     ? io_sw.transmit : '0;
      r_busy      <= (r_state != ST_RX);
      r_sel_error <= r_sel_error || ((r_state == ST_RX) && !w_sel_in_range);
    end
  end

`ifdef TR_SWITCH_TX_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // TX burst limit. r_tx_cnt counts TX-state cycles; when it reaches
  // TX_MAX_CYC the grant is withheld and the sequencer returns to RX. The
  // lockout keeps a still-high request from restarting a burst until it has
  // been seen low.
  // ---------------------------------------------------------------------------
  localparam int TXC_W = $clog2(TX_MAX_CYC + 1);

  logic [TXC_W-1:0] r_tx_cnt;
  logic             r_tx_lockout;
  logic             r_tx_timeout;

  assign w_tx_expired = (r_state == ST_TX) && (r_tx_cnt == TXC_W'(TX_MAX_CYC));
  assign w_tx_blocked = r_tx_lockout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_cnt     <= '0;
      r_tx_lockout <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      if (r_state != ST_TX) begin
        r_tx_cnt <= '0;
      end else if (!w_tx_expired) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end

      if (w_tx_expired) begin
        r_tx_lockout <= 1'b1;
      end else if (!io_sw.tx_request) begin
        r_tx_lockout <= 1'b0;
      end

      r_tx_timeout <= r_tx_timeout || w_tx_expired;
    end
  end

  assign o_tx_timeout = r_tx_timeout;
`else
  assign w_tx_expired = 1'b0;
  assign w_tx_blocked = 1'b0;
`endif

  assign io_sw.tx_grant        = r_tx_grant;
  assign io_sw.tx_out          = r_tx_out;
  assign io_sw.rx_valid        = r_rx_valid;
  assign io_sw.receive         = r_receive;
  assign io_sw.enable_transmit = r_en_tx;
  assign io_sw.enable_receive  = r_en_rx;
  assign io_sw.busy            = r_busy;
  assign io_sw.sel_error       = r_sel_error;

endmodule
